// File: rtl/lcd_bus_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_bus_receiver
// Description : Passive HD44780 bus snooper. Synchronizes the asynchronous
//               rs/rw/en/data bus, tracks the controller address counter and
//               entry mode, and queues every captured write as a record
//               {rs, byte, addr} in a small FIFO. Status reads return
//               {busy, AC}. Busy-time emulation is built only when the macro
//               LCD_RX_BUSY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_receiver #(
  parameter int BUSY_SHORT = 1850,
  parameter int BUSY_LONG  = 76000,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       lcd_controller_rs,
  input  logic       lcd_controller_rw,
  input  logic       lcd_controller_en,
  input  logic [7:0] lcd_controller_lcd,
  output logic [7:0] rd_data,
  output logic       rec_valid,
  input  logic       rec_ready,
  output logic       rec_rs,
  output logic [7:0] rec_byte,
  output logic [6:0] rec_addr,
  output logic       busy,
  output logic       err_busy,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int REC_W = 16;

  // Synchronizer stages, packed as {rs, rw, en, data}
  logic [10:0]      sync_1;
  logic [10:0]      sync_2;
  logic             en_s;
  logic             rs_s;
  logic             rw_s;
  logic [7:0]       data_s;

  // Bus values captured while en is high, and edge detection
  logic             en_prev;
  logic             lat_rs;
  logic             lat_rw;
  logic [7:0]       lat_data;
  logic             en_rise;
  logic             en_fall;
  logic             wr_fire;

  // Address counter and entry-mode increment/decrement bit
  logic [6:0]       ac;
  logic [6:0]       ac_next;
  logic             id;
  logic             id_next;

  // Record FIFO
  logic             push_req;
  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             overflow_q;

  assign en_s   = sync_2[8];
  assign rs_s   = sync_2[10];
  assign rw_s   = sync_2[9];
  assign data_s = sync_2[7:0];

  // Two-flop synchronizer for every bus input
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {lcd_controller_rs, lcd_controller_rw, lcd_controller_en, lcd_controller_lcd};
      sync_2 <= sync_1;
    end
  end

  // Remember en and the last bus values seen while en was high
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      en_prev  <= 1'b0;
      lat_rs   <= 1'b0;
      lat_rw   <= 1'b0;
      lat_data <= '0;
    end else begin
      en_prev <= en_s;
      if (en_s) begin
        lat_rs   <= rs_s;
        lat_rw   <= rw_s;
        lat_data <= data_s;
      end
    end
  end

  // en_prev restarts at 0, so a fall needs en seen high after reset release
  assign en_rise = en_s & ~en_prev;
  assign en_fall = ~en_s & en_prev;
  assign wr_fire = en_fall & ~lat_rw;

  // Decode the completed transfer into the next AC / ID values
  always_comb begin
    ac_next = ac;
    id_next = id;
    if (en_fall) begin
      if (lat_rs) begin
        // Data write and data read both step AC in the entry direction
        ac_next = id ? (ac + 7'd1) : (ac - 7'd1);
      end else if (!lat_rw) begin
        if (lat_data == 8'h01) begin
          ac_next = '0;
          id_next = 1'b1;
        end else if (lat_data[7:1] == 7'b0000001) begin
          ac_next = '0;
        end else if (lat_data[7:2] == 6'b000001) begin
          id_next = lat_data[1];
        end else if (lat_data[7]) begin
          ac_next = lat_data[6:0];
        end
      end
    end
  end

  // AC/ID state and the one-cycle-delayed record push request
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ac       <= '0;
      id       <= 1'b1;
      push_req <= 1'b0;
      push_rec <= '0;
    end else begin
      ac       <= ac_next;
      id       <= id_next;
      push_req <= wr_fire;
      if (wr_fire) begin
        // Address is the AC value before this transfer updates it
        push_rec <= {lat_rs, lat_data, ac};
      end
    end
  end

  // Read response: status reads return {busy, AC}, data reads return zero
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rd_data <= '0;
    end else if (en_rise && rw_s) begin
      rd_data <= rs_s ? 8'h00 : {busy, ac};
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop        = ~fifo_empty & rec_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok    = push_req & (~fifo_full | pop);

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
      end
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; pointers alone define occupancy so the array needs no reset
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && push_ok) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= push_rec;
    end
  end

  assign rec_valid = ~fifo_empty;
  assign overflow  = overflow_q;
  // Outputs are forced to zero when empty so stale storage never shows
  assign {rec_rs, rec_byte, rec_addr} = fifo_empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

`ifdef LCD_RX_BUSY_EN
  localparam int BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int CNT_W    = $clog2(BUSY_MAX + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             err_busy_q;
  logic             long_cmd;

  // Clear display and return home take the long execution time
  assign long_cmd = ~lat_rs & ((lat_data == 8'h01) || (lat_data[7:1] == 7'b0000001));

  // Busy counter reloads on every write; a write while busy is flagged
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      busy_cnt   <= '0;
      err_busy_q <= 1'b0;
    end else if (wr_fire) begin
      busy_cnt <= long_cmd ? CNT_W'(BUSY_LONG) : CNT_W'(BUSY_SHORT);
      if (busy_cnt != '0) begin
        err_busy_q <= 1'b1;
      end
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

  assign busy     = (busy_cnt != '0);
  assign err_busy = err_busy_q;
`else
  assign busy     = 1'b0;
  assign err_busy = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_bus_receiver
// Description : Scoreboard bench for lcd_bus_receiver. Bus transfers are
//               driven as HD44780 cycles; a reference model of the address
//               counter predicts each write record, and a monitor pops and
//               compares records whenever the DUT hands one over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_receiver;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic       rs;
    logic [7:0] b;
    logic [6:0] a;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       rec_ready;
  wire  [7:0] rd_data;
  wire        rec_valid;
  wire        rec_rs;
  wire  [7:0] rec_byte;
  wire  [6:0] rec_addr;
  wire        busy;
  wire        err_busy;
  wire        overflow;

  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  int   ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  rec_t exp_q[$];
  int   m_ac = 0;
  bit   m_id = 1'b1;
  bit   exp_ovf = 1'b0;

  lcd_bus_receiver #(
    .BUSY_SHORT(1850),
    .BUSY_LONG (76000),
    .FIFO_AW   (2)
  ) dut (
    .clk_clk           (clk),
    .reset_reset_n     (rst_n),
    .lcd_controller_rs (lcd_rs),
    .lcd_controller_rw (lcd_rw),
    .lcd_controller_en (lcd_en),
    .lcd_controller_lcd(lcd_data),
    .rd_data           (rd_data),
    .rec_valid         (rec_valid),
    .rec_ready         (rec_ready),
    .rec_rs            (rec_rs),
    .rec_byte          (rec_byte),
    .rec_addr          (rec_addr),
    .busy              (busy),
    .err_busy          (err_busy),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive rec_ready shortly after each rising edge so it is stable at sampling
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       rec_ready = 1'b0;
      1:       rec_ready = 1'b1;
      default: rec_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every handshake pops the oldest expected record and compares
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", {rec_rs, rec_byte, rec_addr}, 32'hFFFF_FFFF);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("record", {rec_rs, rec_byte, rec_addr}, e);
        popped++;
      end
    end
  end

  // One complete HD44780 bus cycle: setup, en high pulse, en low hold
  task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d);
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = d;
    repeat (2) @(posedge clk);
    #2 lcd_en = 1'b1;
    repeat (4) @(posedge clk);
    #2 lcd_en = 1'b0;
    repeat (6) @(posedge clk);
    #2;
  endtask

  function automatic int step_ac(input int ac, input bit id);
    return id ? (ac + 1) % 128 : (ac + 127) % 128;
  endfunction

  // Predict the record and the controller state change, then drive the write
  task automatic do_write(input bit rs, input logic [7:0] d);
    rec_t r;
    int   v;
    v    = int'(d);
    r.rs = rs;
    r.b  = d;
    r.a  = 7'(m_ac);
    if (exp_q.size() < DEPTH) exp_q.push_back(r);
    else exp_ovf = 1'b1;
    if (rs) begin
      m_ac = step_ac(m_ac, m_id);
    end else if (v == 1) begin
      m_ac = 0;
      m_id = 1'b1;
    end else if (v == 2 || v == 3) begin
      m_ac = 0;
    end else if (v >= 4 && v <= 7) begin
      m_id = bit'((v / 2) % 2);
    end else if (v >= 128) begin
      m_ac = v - 128;
    end
    bus_xfer(rs, 1'b0, d);
  endtask

  task automatic rd_status();
    bus_xfer(1'b0, 1'b1, 8'h00);
    check("status_ac", rd_data[6:0], m_ac);
`ifndef LCD_RX_BUSY_EN
    check("status_busy_bit", rd_data[7], 0);
`endif
  endtask

  task automatic rd_dataread();
    bus_xfer(1'b1, 1'b1, 8'h00);
    m_ac = step_ac(m_ac, m_id);
    check("dataread_zero", rd_data, 0);
  endtask

  task automatic wait_room();
    int n = 0;
    while (exp_q.size() >= DEPTH && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) check("wait_room_timeout", exp_q.size(), DEPTH - 1);
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drained_empty", rec_valid, 0);
  endtask

  function automatic logic [7:0] rand_instr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'($urandom_range(4, 7));
      2:       return 8'h80 | 8'($urandom_range(0, 127));
      default: return 8'($urandom_range(1, 3));
    endcase
  endfunction

  initial begin
    int pop_base;
    int n;
    bit ok;
    logic [31:0] exp_err;
`ifdef LCD_RX_BUSY_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif

    // Reset state
    ready_mode = 0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rec_outputs", {rec_valid, rec_rs, rec_byte, rec_addr}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_flags", {busy, err_busy, overflow}, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    ready_mode = 1;

    // Set address, then two data writes
    do_write(1'b0, 8'h80);
    do_write(1'b1, 8'h41);
    do_write(1'b1, 8'h42);
    rd_status();
    check("ac_after_two_data", rd_data[6:0], 7'h02);
    drain();

    // Decrement mode wraps below zero, increment mode wraps above 0x7F
    do_write(1'b0, 8'h80);
    do_write(1'b0, 8'h04);
    do_write(1'b1, 8'h30);
    rd_status();
    check("ac_wrap_down", rd_data[6:0], 7'h7F);
    do_write(1'b0, 8'h06);
    do_write(1'b0, 8'hFF);
    do_write(1'b1, 8'h55);
    rd_status();
    check("ac_wrap_up", rd_data[6:0], 7'h00);
    drain();

    // Randomized traffic with a randomly stalling consumer
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 9);
      wait_room();
      if (k < 4)      do_write(1'b1, 8'($urandom_range(0, 255)));
      else if (k < 7) do_write(1'b0, rand_instr());
      else if (k < 9) rd_status();
      else            rd_dataread();
    end
    drain();
    check("no_overflow_yet", overflow, exp_ovf);

    // Five writes into a stalled four-entry FIFO
    ready_mode = 0;
    repeat (3) @(posedge clk);
    pop_base = popped;
    for (int i = 0; i < 5; i++) do_write(1'b1, 8'(8'hA0 + i));
    @(negedge clk);
    check("overflow_set", overflow, exp_ovf);
    check("overflow_expected", exp_ovf, 1);
    check("full_valid", rec_valid, 1);
    drain();
    check("drained_four", popped - pop_base, 4);

    // Clear display followed by a status read
    do_write(1'b0, 8'h01);
    repeat (2) @(posedge clk);
    bus_xfer(1'b0, 1'b1, 8'h00);
`ifdef LCD_RX_BUSY_EN
    check("clear_status", rd_data, 8'h80);
    n = 0;
    while (busy && n < 80000) begin
      @(posedge clk);
      n++;
    end
    ok = (n > 75900) && (n < 76000);
    check("busy_long_window", ok, 1);
`else
    check("clear_status", rd_data, 8'h00);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("busy_never_set", n, 0);
`endif
    check("err_busy_sticky", err_busy, exp_err);
    check("overflow_sticky", overflow, 1);
    drain();

    // Leave a record queued and a nonzero rd_data, then reset mid-transfer
    do_write(1'b0, 8'h85);
    rd_status();
    ready_mode = 0;
    do_write(1'b1, 8'h66);
    lcd_rs   = 1'b1;
    lcd_rw   = 1'b0;
    lcd_data = 8'h77;
    repeat (2) @(posedge clk);
    #2 lcd_en = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 lcd_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_rec_outputs", {rec_valid, rec_rs, rec_byte, rec_addr}, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_flags", {busy, err_busy, overflow}, 0);
    exp_q.delete();
    m_ac    = 0;
    m_id    = 1'b1;
    exp_ovf = 1'b0;
    rst_n   = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("postrst_no_record", rec_valid, 0);
    check("postrst_flags", {err_busy, overflow}, 0);
    ready_mode = 1;
    do_write(1'b1, 8'h12);
    drain();
    rd_status();
    check("postrst_ac", rd_data[6:0], 7'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter BUSY_SHORT, 1850, busy cycles after any accepted write except clear/home.
REQ-002 SHALL have parameter BUSY_LONG, 76000, busy cycles after clear display (0x01) or return home (0x02/0x03).
REQ-003 SHALL have parameter FIFO_AW, 2, record FIFO address width (depth 2**FIFO_AW).
REQ-004 SHALL have port clk_clk  in  1  sole clock.
REQ-005 SHALL have port reset_reset_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports lcd_controller_rs / _rw / _en  in  1 each  HD44780 bus control, asynchronous to clk_clk.
REQ-007 SHALL have port lcd_controller_lcd  in  8  HD44780 data bus.
REQ-008 SHALL have port rd_data  out  8  read response: {busy, AC[6:0]}, or 0x00 for data reads.
REQ-009 SHALL have ports rec_valid out 1, rec_ready in 1, rec_rs out 1, rec_byte out 8, rec_addr out 7: captured-write record stream.
REQ-010 SHALL have ports busy out 1, err_busy out 1 (sticky), overflow out 1 (sticky).

Function
REQ-011 SHALL pass rs, rw, en, data through a 2-flop synchronizer before any use.
REQ-012 SHALL detect a transfer on the synchronized en high->low transition; rs/rw/data SHALL be the synchronized values from the last cycle en was high.
REQ-013 SHALL keep a 7-bit address counter AC and entry-mode bit ID (reset 1).
REQ-014 Write rw=0, rs=0 (instruction): 0x01 -> AC=0, ID=1; 0x02/0x03 -> AC=0; 0b000001xx -> ID=data[1]; data[7]=1 -> AC=data[6:0]; all other codes leave AC/ID unchanged.
REQ-015 Write rw=0, rs=1 (data): record addr = AC before update; then AC += 1 if ID=1, else AC -= 1, modulo 128 (0x7F+1 -> 0x00, 0x00-1 -> 0x7F).
REQ-016 Every write SHALL push {rs, data, addr} to the FIFO one cycle after the falling edge is detected; for instructions addr = AC before the instruction.
REQ-017 Read rw=1, rs=0: rd_data SHALL load {busy, AC} on the cycle the synchronized en rises and hold until the next read; AC unchanged, nothing pushed.
REQ-018 Read rw=1, rs=1: rd_data SHALL load 0x00; AC SHALL step per ID on the falling edge; nothing pushed.
REQ-019 FIFO: rec_valid=1 iff not empty; head popped when rec_valid and rec_ready are both 1; rec_rs/byte/addr SHALL show the head record and remain stable while rec_valid=1 and rec_ready=0.
REQ-020 Push when full with no simultaneous pop SHALL drop the record and set overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-021 Each accepted write SHALL load the busy counter with BUSY_LONG or BUSY_SHORT; busy=1 while the counter is nonzero; the counter decrements by 1 per cycle.
REQ-022 A write arriving while busy=1 SHALL still be decoded and pushed, SHALL set err_busy, and SHALL reload the counter.
REQ-023 overflow and err_busy SHALL clear only on reset.

Reset
REQ-024 While reset_reset_n=0 at a rising edge: FIFO empty, rec_valid=0, rec_rs=0, rec_byte=0, rec_addr=0, rd_data=0x00, AC=0, ID=1, busy counter=0, busy=0, err_busy=0, overflow=0, synchronizers=0.
REQ-025 A transfer in progress when reset asserts SHALL be discarded; after release, an en falling edge SHALL be recognized only if en was sampled high after release.

Configuration
REQ-026 Macro LCD_RX_BUSY_EN defined: busy timing per REQ-021/022.
REQ-027 LCD_RX_BUSY_EN undefined: no busy counter; busy=0, err_busy=0 permanently, rd_data busy bit 0; all other behaviour unchanged.

Verification
REQ-028 Write instr 0x80 then data 0x41, 0x42 -> records (0,0x80,0x00), (1,0x41,0x00), (1,0x42,0x01); AC=0x02.
REQ-029 Instr 0x04 (ID=0), AC=0x00, write data 0x30 -> record addr 0x00, AC=0x7F; instr 0xFF then data -> AC wraps 0x7F->0x00 with ID=1.
REQ-030 rec_ready=0, 5 writes with FIFO_AW=2 -> 4 records held in order, overflow=1; then rec_ready=1 drains exactly 4 records.
REQ-031 Instr 0x01 then status read (rw=1, rs=0) 10 cycles later -> rd_data[7]=1, rd_data[6:0]=0x00; busy stays 1 for 76000 cycles (macro defined) or 0 throughout (undefined).
REQ-032 Write during busy -> record pushed, err_busy=1; reset pulse mid-transfer (en high) -> all outputs at REQ-024 values, no record pushed.
